div16: RTL and testbench

- Sequential fixed-point divider; the inverse of the butterfly's 17-bit × 8-bit twiddle multiplier. It undoes a twiddle scaling, as used by IFFT normalisation and by the butterfly self-check.
- Computes `out = trunc((in_17bit × 128) / in_8bit)`, with the divisor in Q1.7 and rounding toward zero. The result saturates to 17-bit two's complement.
- Radix-2 restoring division on magnitudes, one quotient bit per clock.
- Valid/ready handshake on both sides.

---
 rtl/div16_pkg.sv | 43 ++++
 rtl/div16_step.sv | 22 ++
 rtl/div16.sv | 111 +++++++++++
 tb/tb_div16.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/div16_pkg.sv
// div16 shared constants, state encoding and the sign-fix/saturation helper.
package div16_pkg;

  localparam int DW   = 17;
  localparam int TW   = 8;
  localparam int FRAC = 7;
  localparam int NUMW = DW + FRAC;
  localparam int ITER = 24;
  localparam int RW   = TW + 1;
  localparam int CW   = 5;

  localparam int Q_MAX = 65535;
  localparam int Q_MIN = -65536;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  typedef struct packed {
    logic [DW-1:0] q;
    logic          sat;
  } fix_t;

  // A negative result may reach one step further (65536) than a positive one.
  function automatic fix_t sat_fix(
    input logic [NUMW-1:0] mag,
    input logic            neg
  );
    fix_t          r;
    logic [NUMW-1:0] lim;
    lim   = neg ? NUMW'(-Q_MIN) : NUMW'(Q_MAX);
    r.sat = (mag > lim);
    if (r.sat)
      r.q = neg ? DW'(Q_MIN) : DW'(Q_MAX);
    else
      r.q = neg ? DW'(-mag) : DW'(mag);
    return r;
  endfunction

endpackage

// File: rtl/div16_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div16_step
  import div16_pkg::*;
(
  input  logic [RW-1:0] rem,
  input  logic          bit_in,
  input  logic [TW-1:0] dvs,
  output logic [RW-1:0] rem_next,
  output logic          q
);

  logic [RW-1:0] sh;
  logic [RW-1:0] dx;

  always_comb begin
    sh       = {rem[RW-2:0], bit_in};
    dx       = {1'b0, dvs};
    q        = (sh >= dx);
    rem_next = q ? (sh - dx) : sh;
  end

endmodule

// File: rtl/div16.sv
// Sequential Q1.7 fixed-point divider: out = trunc(in_17bit*128/in_8bit),
// saturated to 17 bits, one quotient bit per clock.
module div16
  import div16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_17bit,
  input  logic signed [TW-1:0] in_8bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out,
  output logic                 sat,
  output logic                 div_zero
);

  state_t          state;
  logic [NUMW-1:0] num;
  logic [RW-1:0]   rem;
  logic [TW-1:0]   dmag;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            dsign;
  logic            dz;

  logic [DW-1:0]   amag;
  logic [TW-1:0]   bmag;
  logic [RW-1:0]   rem_next;
  logic            qbit;
  fix_t            fx;

  always_comb begin
    amag = in_17bit[DW-1] ? $unsigned(-in_17bit) : $unsigned(in_17bit);
    bmag = in_8bit[TW-1] ? $unsigned(-in_8bit) : $unsigned(in_8bit);
    fx   = sat_fix(num, neg);
  end

  div16_step u_step (
    .rem      (rem),
    .bit_in   (num[NUMW-1]),
    .dvs      (dmag),
    .rem_next (rem_next),
    .q        (qbit)
  );

  // num doubles as numerator shifter and quotient accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      sat       <= 1'b0;
      div_zero  <= 1'b0;
      num       <= '0;
      rem       <= '0;
      dmag      <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      dsign     <= 1'b0;
      dz        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            num      <= {amag, {FRAC{1'b0}}};
            rem      <= '0;
            dmag     <= bmag;
            neg      <= in_17bit[DW-1] ^ in_8bit[TW-1];
            dsign    <= in_17bit[DW-1];
            dz       <= (in_8bit == '0);
            cnt      <= CW'(ITER);
            in_ready <= 1'b0;
            state    <= (in_8bit == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem <= rem_next;
          num <= {num[NUMW-2:0], qbit};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= FIX;
        end
        FIX: begin
          if (dz) begin
            out      <= dsign ? DW'(Q_MIN) : DW'(Q_MAX);
            sat      <= 1'b1;
            div_zero <= 1'b1;
          end else begin
            out      <= fx.q;
            sat      <= fx.sat;
            div_zero <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div16.sv
// Self-checking bench for div16: directed cases, random operands against an
// arithmetic reference, backpressure and asynchronous reset mid-calculation.
module tb_div16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [16:0] in_17bit;
  logic signed [7:0]  in_8bit;
  logic               out_valid;
  logic               out_ready;
  logic signed [16:0] out;
  logic               sat;
  logic               div_zero;

  int checks = 0;
  int errors = 0;

  div16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_17bit  (in_17bit),
    .in_8bit   (in_8bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .sat       (sat),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_op(input longint a, input longint b, input bit hold);
    longint q;
    bit     s;
    bit     z;
    int     edges;
    logic signed [16:0] held;
    s = 0;
    z = (b == 0);
    if (z) begin
      s = 1;
      q = (a >= 0) ? 65535 : -65536;
    end else begin
      q = (a * 128) / b;
      if (q > 65535) begin q = 65535; s = 1; end
      else if (q < -65536) begin q = -65536; s = 1; end
    end
    chk("in_ready_before", in_ready, 1);
    in_valid = 1'b1;
    in_17bit = 17'(a);
    in_8bit  = 8'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_17bit = 17'($urandom);
    in_8bit  = 8'($urandom);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, z ? 1 : 25);
    chk("out", out, q);
    chk("sat", sat, s);
    chk("div_zero", div_zero, z);
    if (hold) begin
      held = out;
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        in_17bit = 17'd777;
        in_8bit  = 8'd3;
        @(posedge clk); #1;
        chk("hold_out", out, held);
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_clear", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    longint ra;
    longint rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_17bit  = '0;
    in_8bit   = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_sat", sat, 0);
    chk("rst_div_zero", div_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(4360, 127, 0);
    do_op(4325, 127, 0);
    do_op(1000, 64, 0);
    do_op(-1000, 127, 0);
    do_op(1000, -128, 0);
    do_op(60000, 64, 0);
    do_op(-65536, 1, 0);
    do_op(-32768, 64, 0);
    do_op(-65536, -128, 0);
    do_op(-5, 0, 0);
    do_op(0, 0, 0);
    do_op(1000, 64, 1);
    do_op(-300, 7, 0);

    // Abort part way through the iterations with an asynchronous reset.
    in_valid = 1'b1;
    in_17bit = 17'sd12345;
    in_8bit  = 8'sd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out", out, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(256, 127, 0);

    for (int i = 0; i < 40; i++) begin
      ra = longint'($signed(17'($urandom)));
      rb = ($urandom_range(0, 7) == 0) ? 0 : longint'($signed(8'($urandom)));
      do_op(ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
